// File: rtl/lru_cache_ctrl.sv
// lru_cache_ctrl: sequences one CPU load/store at a time onto the LRU_Cache
// active-low RD_/WR_ strobe protocol. It handles read-miss fetch, write-allocate
// and write-back of dirty evicted lines, and gives the CPU a request/done
// handshake.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   cpu_*               CPU request (req/we/tag/wdata) and response
//                       (ready/done/rdata/hit)
//   c_*                 cache strobes, tag and data out; miss/evict flags in
//   mem_*               lower-memory read/write request, held until mem_ack
//   stat_hits/misses/wbs  saturating statistics counters
//
// Optional feature: define LRU_CTRL_STATS_EN to build the statistics counters.
// Without it, the stat_* outputs are tied to zero.
module lru_cache_ctrl #(
  parameter int unsigned TAG_WIDTH   = 4,
  parameter int unsigned VALUE_WIDTH = 32,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [TAG_WIDTH-1:0]   cpu_tag,
  input  logic [VALUE_WIDTH-1:0] cpu_wdata,
  output logic                   cpu_ready,
  output logic                   cpu_done,
  output logic [VALUE_WIDTH-1:0] cpu_rdata,
  output logic                   cpu_hit,
  output logic                   c_select,
  output logic [TAG_WIDTH-1:0]   c_input_tag,
  output logic [VALUE_WIDTH-1:0] c_new_value,
  output logic                   c_RD_,
  output logic                   c_WR_,
  output logic                   c_is_new,
  input  logic                   c_cache_miss,
  input  logic                   c_memwrite,
  input  logic [TAG_WIDTH-1:0]   c_tag_write,
  input  logic [VALUE_WIDTH-1:0] c_value_write,
  output logic                   mem_rd_req,
  output logic                   mem_wr_req,
  output logic [TAG_WIDTH-1:0]   mem_tag,
  output logic [VALUE_WIDTH-1:0] mem_wdata,
  input  logic                   mem_ack,
  input  logic [VALUE_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]   stat_hits,
  output logic [CNT_WIDTH-1:0]   stat_misses,
  output logic [CNT_WIDTH-1:0]   stat_wbs
);

  typedef enum logic [2:0] {
    StIdle, StLookup, StCheck, StFetch, StFill, StFcheck, StWb, StResp
  } state_e;

  state_e r_state, w_state_d;

  // Request and line data
  logic [TAG_WIDTH-1:0]   r_tag, w_tag_d;
  logic                   r_we, w_we_d;
  logic [VALUE_WIDTH-1:0] r_wdata, w_wdata_d;
  logic [VALUE_WIDTH-1:0] r_fill, w_fill_d;
  logic [VALUE_WIDTH-1:0] r_rdata, w_rdata_d;
  logic                   r_hit, w_hit_d;
  logic [TAG_WIDTH-1:0]   r_ev_tag, w_ev_tag_d;
  logic [VALUE_WIDTH-1:0] r_ev_data, w_ev_data_d;
  // Set once the fetch has been acked; FETCH then spends one turnaround cycle
  // with the request dropped before the fill write is issued.
  logic                   r_fetched, w_fetched_d;

  // Registered outputs and their next values
  logic                   r_done, w_done_d;
  logic                   r_cpu_hit, w_cpu_hit_d;
  logic                   r_sel, w_sel_d;
  logic [TAG_WIDTH-1:0]   r_in_tag, w_in_tag_d;
  logic [VALUE_WIDTH-1:0] r_new_val, w_new_val_d;
  logic                   r_rd_n, w_rd_n_d;
  logic                   r_wr_n, w_wr_n_d;
  logic                   r_is_new, w_is_new_d;
  logic                   r_mrd, w_mrd_d;
  logic                   r_mwr, w_mwr_d;
  logic [TAG_WIDTH-1:0]   r_mtag, w_mtag_d;
  logic [VALUE_WIDTH-1:0] r_mwdata, w_mwdata_d;

  // Acks only count while the matching request is actually on the bus.
  logic w_rd_ack, w_wr_ack;
  assign w_rd_ack = r_mrd & mem_ack;
  assign w_wr_ack = r_mwr & mem_ack;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Next state and datapath captures
  always_comb begin
    w_state_d   = r_state;
    w_tag_d     = r_tag;
    w_we_d      = r_we;
    w_wdata_d   = r_wdata;
    w_fill_d    = r_fill;
    w_rdata_d   = r_rdata;
    w_hit_d     = r_hit;
    w_ev_tag_d  = r_ev_tag;
    w_ev_data_d = r_ev_data;
    w_fetched_d = r_fetched;
    unique case (r_state)
      StIdle: begin
        if (cpu_req) begin
          w_tag_d   = cpu_tag;
          w_we_d    = cpu_we;
          w_wdata_d = cpu_wdata;
          w_state_d = StLookup;
        end
      end
      StLookup: w_state_d = StCheck;
      StCheck: begin
        w_hit_d = ~c_cache_miss;
        if (!c_cache_miss) begin
          if (!r_we) w_rdata_d = c_value_write;
          w_state_d = StResp;
        end else if (r_we) begin
          w_fill_d  = r_wdata;
          w_state_d = StFill;
        end else begin
          w_fetched_d = 1'b0;
          w_state_d   = StFetch;
        end
      end
      StFetch: begin
        if (r_fetched) begin
          w_state_d = StFill;
        end else if (w_rd_ack) begin
          w_fill_d    = mem_rdata;
          w_rdata_d   = mem_rdata;
          w_fetched_d = 1'b1;
        end
      end
      StFill: w_state_d = StFcheck;
      StFcheck: begin
        if (c_memwrite) begin
          w_ev_tag_d  = c_tag_write;
          w_ev_data_d = c_value_write;
          w_state_d   = StWb;
        end else begin
          w_state_d = StResp;
        end
      end
      StWb: begin
        if (w_wr_ack) w_state_d = StResp;
      end
      StResp: w_state_d = StIdle;
    endcase
  end

  // Output decode for the upcoming state; registered below
  always_comb begin
    w_done_d    = 1'b0;
    w_cpu_hit_d = 1'b0;
    w_sel_d     = 1'b0;
    w_in_tag_d  = '0;
    w_new_val_d = '0;
    w_rd_n_d    = 1'b1;
    w_wr_n_d    = 1'b1;
    w_is_new_d  = 1'b0;
    w_mrd_d     = 1'b0;
    w_mwr_d     = 1'b0;
    w_mtag_d    = '0;
    w_mwdata_d  = '0;
    unique case (w_state_d)
      StIdle: ;
      StLookup: begin
        w_sel_d    = 1'b1;
        w_in_tag_d = w_tag_d;
        if (w_we_d) begin
          w_wr_n_d    = 1'b0;
          w_new_val_d = w_wdata_d;
        end else begin
          w_rd_n_d = 1'b0;
        end
      end
      StCheck, StFcheck: begin
        w_sel_d    = 1'b1;
        w_in_tag_d = w_tag_d;
      end
      StFetch: begin
        w_mrd_d  = ~w_fetched_d;
        w_mtag_d = w_fetched_d ? '0 : w_tag_d;
      end
      StFill: begin
        w_sel_d     = 1'b1;
        w_in_tag_d  = w_tag_d;
        w_wr_n_d    = 1'b0;
        w_is_new_d  = 1'b1;
        w_new_val_d = w_fill_d;
      end
      StWb: begin
        w_mwr_d    = 1'b1;
        w_mtag_d   = w_ev_tag_d;
        w_mwdata_d = w_ev_data_d;
      end
      StResp: begin
        w_done_d    = 1'b1;
        w_cpu_hit_d = w_hit_d;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag     <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_fill    <= '0;
      r_rdata   <= '0;
      r_hit     <= 1'b0;
      r_ev_tag  <= '0;
      r_ev_data <= '0;
      r_fetched <= 1'b0;
      r_done    <= 1'b0;
      r_cpu_hit <= 1'b0;
      r_sel     <= 1'b0;
      r_in_tag  <= '0;
      r_new_val <= '0;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_is_new  <= 1'b0;
      r_mrd     <= 1'b0;
      r_mwr     <= 1'b0;
      r_mtag    <= '0;
      r_mwdata  <= '0;
    end else begin
      r_tag     <= w_tag_d;
      r_we      <= w_we_d;
      r_wdata   <= w_wdata_d;
      r_fill    <= w_fill_d;
      r_rdata   <= w_rdata_d;
      r_hit     <= w_hit_d;
      r_ev_tag  <= w_ev_tag_d;
      r_ev_data <= w_ev_data_d;
      r_fetched <= w_fetched_d;
      r_done    <= w_done_d;
      r_cpu_hit <= w_cpu_hit_d;
      r_sel     <= w_sel_d;
      r_in_tag  <= w_in_tag_d;
      r_new_val <= w_new_val_d;
      r_rd_n    <= w_rd_n_d;
      r_wr_n    <= w_wr_n_d;
      r_is_new  <= w_is_new_d;
      r_mrd     <= w_mrd_d;
      r_mwr     <= w_mwr_d;
      r_mtag    <= w_mtag_d;
      r_mwdata  <= w_mwdata_d;
    end
  end

  assign cpu_ready   = (r_state == StIdle);
  assign cpu_done    = r_done;
  assign cpu_rdata   = r_rdata;
  assign cpu_hit     = r_cpu_hit;
  assign c_select    = r_sel;
  assign c_input_tag = r_in_tag;
  assign c_new_value = r_new_val;
  assign c_RD_       = r_rd_n;
  assign c_WR_       = r_wr_n;
  assign c_is_new    = r_is_new;
  assign mem_rd_req  = r_mrd;
  assign mem_wr_req  = r_mwr;
  assign mem_tag     = r_mtag;
  assign mem_wdata   = r_mwdata;

`ifdef LRU_CTRL_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CntOne = 1;

  logic [CNT_WIDTH-1:0] r_stat_hits, r_stat_misses, r_stat_wbs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_wbs    <= '0;
    end else begin
      if (r_state == StCheck) begin
        if (!c_cache_miss) begin
          if (r_stat_hits != '1) r_stat_hits <= r_stat_hits + CntOne;
        end else begin
          if (r_stat_misses != '1) r_stat_misses <= r_stat_misses + CntOne;
        end
      end
      if (w_wr_ack && (r_stat_wbs != '1)) r_stat_wbs <= r_stat_wbs + CntOne;
    end
  end

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;
  assign stat_wbs    = r_stat_wbs;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
  assign stat_wbs    = '0;
`endif

endmodule

// File: tb/tb_lru_cache_ctrl.sv
// Self-checking bench for lru_cache_ctrl. A 4-way LRU cache and a lower memory
// with programmable ack delay are modelled around the DUT. A transaction-level
// reference (tag queue in LRU order) predicts hit/miss, data, evictions and
// the per-cycle strobe/request timeline for each request.
module tb_lru_cache_ctrl;

  logic        clk, rst, cpu_req, cpu_we;
  logic [3:0]  cpu_tag;
  logic [31:0] cpu_wdata;
  logic        cpu_ready, cpu_done, cpu_hit;
  logic [31:0] cpu_rdata;
  logic        c_select, c_RD_, c_WR_, c_is_new;
  logic [3:0]  c_input_tag;
  logic [31:0] c_new_value;
  logic        c_cache_miss, c_memwrite;
  logic [3:0]  c_tag_write;
  logic [31:0] c_value_write;
  logic        mem_rd_req, mem_wr_req, mem_ack;
  logic [3:0]  mem_tag;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] stat_hits, stat_misses, stat_wbs;

  lru_cache_ctrl #(.TAG_WIDTH(4), .VALUE_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_tag(cpu_tag), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .c_select(c_select), .c_input_tag(c_input_tag), .c_new_value(c_new_value),
    .c_RD_(c_RD_), .c_WR_(c_WR_), .c_is_new(c_is_new),
    .c_cache_miss(c_cache_miss), .c_memwrite(c_memwrite), .c_tag_write(c_tag_write),
    .c_value_write(c_value_write),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_tag(mem_tag),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbs(stat_wbs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- cache environment (responds the cycle after a strobe)
  logic        e_valid [4];
  logic [3:0]  e_tag   [4];
  logic [31:0] e_data  [4];
  logic        e_dirty [4];
  int          e_stamp [4];
  int          e_time;

  always @(negedge clk) begin : cache_env
    int hi, vi;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        e_valid[i] = 1'b0; e_dirty[i] = 1'b0; e_stamp[i] = 0; e_tag[i] = '0; e_data[i] = '0;
      end
      e_time = 0;
      c_cache_miss = 1'b0; c_memwrite = 1'b0; c_tag_write = '0; c_value_write = '0;
    end else if (!c_RD_ || !c_WR_) begin
      e_time++;
      hi = -1;
      for (int i = 0; i < 4; i++) if (e_valid[i] && e_tag[i] == c_input_tag) hi = i;
      if (!c_RD_) begin
        c_memwrite = 1'b0;
        if (hi >= 0) begin
          c_cache_miss = 1'b0; c_value_write = e_data[hi]; e_stamp[hi] = e_time;
        end else c_cache_miss = 1'b1;
      end else if (!c_is_new) begin
        c_memwrite = 1'b0;
        if (hi >= 0) begin
          c_cache_miss = 1'b0; e_data[hi] = c_new_value; e_dirty[hi] = 1'b1;
          e_stamp[hi] = e_time;
        end else c_cache_miss = 1'b1;
      end else begin
        vi = hi;
        if (vi < 0) for (int i = 0; i < 4; i++) if (!e_valid[i] && vi < 0) vi = i;
        if (vi < 0) begin
          vi = 0;
          for (int i = 1; i < 4; i++) if (e_stamp[i] < e_stamp[vi]) vi = i;
        end
        c_memwrite    = e_valid[vi] && e_dirty[vi] && (hi < 0);
        c_tag_write   = e_tag[vi];
        c_value_write = e_data[vi];
        c_cache_miss  = 1'b0;
        e_valid[vi] = 1'b1; e_tag[vi] = c_input_tag; e_data[vi] = c_new_value;
        e_dirty[vi] = 1'b1; e_stamp[vi] = e_time;
      end
    end
  end

  // ---------------- lower memory: ack after a programmable number of cycles
  int rd_delay = 0;
  int wr_delay = 0;
  int m_cnt    = 0;

  always @(negedge clk) begin : mem_env
    if (mem_rd_req || mem_wr_req) begin
      mem_ack = (m_cnt == (mem_rd_req ? rd_delay : wr_delay));
      m_cnt++;
    end else begin
      mem_ack = 1'b0;
      m_cnt   = 0;
    end
  end

  // ---------------- reference model (transaction level)
  logic [3:0]  m_q [$];
  logic [31:0] m_data [16];
  int m_hits = 0, m_misses = 0, m_wbs = 0;

  // Expectations for the transaction in flight
  logic        x_we, x_miss, x_wb, x_hit;
  logic [3:0]  x_tag, x_vtag;
  logic [31:0] x_wdata, x_fill_data, x_rdata, x_vdata;
  int          x_k, x_j, x_fill, x_fcheck, x_done;
  logic        active = 1'b0;
  int          cyc = 0;
  int          seen_done = -1;
  logic [3:0]  seen_wb_tag = '0;
  logic [31:0] seen_rdata = '0;

  // ---------------- compare process: every cycle against the timeline
  always @(negedge clk) begin : compare
    logic e_sel, e_rd_n, e_wr_n, e_new, e_mrd, e_mwr, e_done;
    if (active) begin
      cyc++;
      e_sel  = (cyc == 1) || (cyc == 2) || (x_miss && (cyc == x_fill || cyc == x_fcheck));
      e_rd_n = !(cyc == 1 && !x_we);
      e_wr_n = !((cyc == 1 && x_we) || (x_miss && cyc == x_fill));
      e_new  = x_miss && (cyc == x_fill);
      e_mrd  = x_miss && !x_we && (cyc >= 3) && (cyc <= 3 + x_k);
      e_mwr  = x_wb && (cyc > x_fcheck) && (cyc <= x_fcheck + 1 + x_j);
      e_done = (cyc == x_done);
      chk("ctrl{sel,rd_n,wr_n,is_new,mrd,mwr,done,ready}",
          32'({c_select, c_RD_, c_WR_, c_is_new, mem_rd_req, mem_wr_req, cpu_done, cpu_ready}),
          32'({e_sel, e_rd_n, e_wr_n, e_new, e_mrd, e_mwr, e_done, 1'b0}));
      if (!e_rd_n || !e_wr_n) chk("c_input_tag", 32'(c_input_tag), 32'(x_tag));
      if (!e_wr_n) chk("c_new_value", c_new_value, (cyc == 1) ? x_wdata : x_fill_data);
      if (e_mrd) chk("mem_rd_tag", 32'(mem_tag), 32'(x_tag));
      if (e_mwr) begin
        chk("mem_wr_tag", 32'(mem_tag), 32'(x_vtag));
        chk("mem_wdata", mem_wdata, x_vdata);
        seen_wb_tag = mem_tag;
      end
      if (cpu_done) seen_done = cyc;
      if (e_done) begin
        chk("cpu_hit", 32'(cpu_hit), 32'(x_hit));
        if (!x_we) chk("cpu_rdata", cpu_rdata, x_rdata);
        seen_rdata = cpu_rdata;
        active = 1'b0;
      end
    end else begin
      chk("no_stray_done", 32'(cpu_done), 32'd0);
    end
  end

  task automatic do_txn(input logic we, input logic [3:0] tag, input logic [31:0] wdata,
                        input int k, input int j, input logic [31:0] mrd);
    int idx;
    idx = -1;
    for (int i = 0; i < m_q.size(); i++) if (m_q[i] == tag) idx = i;
    x_we = we; x_tag = tag; x_wdata = wdata; x_k = k; x_j = j;
    x_wb = 1'b0; x_miss = (idx < 0); x_fill = -100; x_fcheck = -100;
    x_vtag = '0; x_vdata = '0; x_fill_data = '0;
    if (idx >= 0) begin
      m_hits++;
      m_q.delete(idx);
      m_q.push_back(tag);
      if (we) m_data[tag] = wdata;
      x_rdata = m_data[tag];
      x_done  = 3;
    end else begin
      m_misses++;
      if (m_q.size() == 4) begin
        x_wb    = 1'b1;
        x_vtag  = m_q.pop_front();
        x_vdata = m_data[x_vtag];
        m_wbs++;
      end
      x_fill_data  = we ? wdata : mrd;
      m_data[tag]  = x_fill_data;
      m_q.push_back(tag);
      x_rdata  = mrd;
      x_fcheck = we ? 4 : 6 + k;
      x_fill   = x_fcheck - 1;
      x_done   = x_fcheck + 1 + (x_wb ? 1 + j : 0);
    end
    x_hit = ~x_miss;
    rd_delay = k; wr_delay = j; mem_rdata = mrd;
    seen_done = -1;
    @(negedge clk); #1;
    chk("ready_before_req", 32'(cpu_ready), 32'd1);
    cpu_req = 1'b1; cpu_we = we; cpu_tag = tag; cpu_wdata = wdata;
    @(posedge clk); #1;
    // A second request while busy must be ignored.
    cpu_we = ~we; cpu_tag = ~tag; cpu_wdata = ~wdata;
    cyc = 0;
    active = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    do begin
      @(negedge clk); #1;
    end while (active);
  endtask

  initial begin
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_tag = '0; cpu_wdata = '0; mem_rdata = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cpu{ready,done,hit}", 32'({cpu_ready, cpu_done, cpu_hit}), 32'b100);
    chk("reset_cpu_rdata", cpu_rdata, 32'd0);
    chk("reset_cache{sel,rd_n,wr_n,is_new}", 32'({c_select, c_RD_, c_WR_, c_is_new}), 32'b0110);
    chk("reset_cache_tag_val", 32'(c_input_tag) | c_new_value, 32'd0);
    chk("reset_mem{rd,wr}", 32'({mem_rd_req, mem_wr_req}), 32'd0);
    chk("reset_mem_tag_data", 32'(mem_tag) | mem_wdata, 32'd0);
    chk("reset_stats", 32'(stat_hits) | 32'(stat_misses) | 32'(stat_wbs), 32'd0);
    cpu_req = 1'b0;
    rst = 1'b0;

    // Write miss into empty cache
    do_txn(1'b1, 4'd5, 32'hA5A5_0005, 0, 0, 32'h0);
    chk("wmiss_done_cycle", 32'(seen_done), 32'd5);
    // Read hit
    do_txn(1'b0, 4'd5, 32'h0, 0, 0, 32'h0);
    chk("rhit_done_cycle", 32'(seen_done), 32'd3);
    chk("rhit_rdata", seen_rdata, 32'hA5A5_0005);
    // Read miss, memory acks 4 cycles after the request rises
    do_txn(1'b0, 4'd13, 32'h0, 4, 0, 32'h1300_00D0);
    chk("rmiss_done_cycle", 32'(seen_done), 32'd11);
    chk("rmiss_rdata", seen_rdata, 32'h1300_00D0);
    // Write hit, then fill the set and force dirty evictions
    do_txn(1'b1, 4'd5, 32'hA5A5_0055, 0, 0, 32'h0);
    chk("whit_done_cycle", 32'(seen_done), 32'd3);
    do_txn(1'b1, 4'd6, 32'hA5A5_0006, 0, 0, 32'h0);
    do_txn(1'b1, 4'd7, 32'hA5A5_0007, 0, 0, 32'h0);
    do_txn(1'b1, 4'd8, 32'hA5A5_0008, 0, 1, 32'h0);
    chk("evict_lru_tag_13", 32'(seen_wb_tag), 32'd13);
    do_txn(1'b1, 4'd9, 32'hA5A5_0009, 0, 2, 32'h0);
    chk("evict_tag_5", 32'(seen_wb_tag), 32'd5);
    chk("evict_done_cycle", 32'(seen_done), 32'd8);
    do_txn(1'b0, 4'd6, 32'h0, 0, 0, 32'h0);
    chk("rhit6_rdata", seen_rdata, 32'hA5A5_0006);

    // Reset during FETCH
    rd_delay = 10; mem_rdata = 32'h0200_00D0;
    @(negedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_tag = 4'd2;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("fetch_req_before_reset", 32'(mem_rd_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("reset_async{mrd,mwr}", 32'({mem_rd_req, mem_wr_req}), 32'd0);
    chk("reset_async{rd_n,wr_n,ready}", 32'({c_RD_, c_WR_, cpu_ready}), 32'b111);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    m_q.delete();
    m_hits = 0; m_misses = 0; m_wbs = 0;

    do_txn(1'b0, 4'd2, 32'h0, 0, 0, 32'h0200_00D0);
    chk("post_reset_done_cycle", 32'(seen_done), 32'd7);
    chk("post_reset_rdata", seen_rdata, 32'h0200_00D0);
    do_txn(1'b0, 4'd2, 32'h0, 0, 0, 32'h0);
    chk("post_reset_hit_rdata", seen_rdata, 32'h0200_00D0);

`ifdef LRU_CTRL_STATS_EN
    chk("stat_hits", 32'(stat_hits), 32'(m_hits));
    chk("stat_misses", 32'(stat_misses), 32'(m_misses));
    chk("stat_wbs", 32'(stat_wbs), 32'(m_wbs));
`else
    chk("stats_tied_zero", 32'(stat_hits) | 32'(stat_misses) | 32'(stat_wbs), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
